spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Command engine between the SPI slave byte interface and the QSPI flash read controller.
- Parses host commands and performs burst reads of 1–256 bytes from a 24-bit flash address.
- Prefetches flash bytes into a small FIFO and streams them back with status/data framing.
- Replaces the single-byte ad-hoc debug read logic.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- ADDR_W, 24, flash address width.

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous reset, active-high
- recv_data  in  8  byte received from SPI slave
- recv_ready  in  1  one-cycle pulse, recv_data valid
- send_data  out  8  reply byte, shifted out by the SPI slave during the next SPI byte
- flash_setup_done  in  1  flash controller finished QSPI setup; level
- flash_addr  out  ADDR_W  read address; stable while flash_do_read is high
- flash_do_read  out  1  read request; level, held until flash_data_ready
- flash_data_ready  in  1  one-cycle pulse, flash_data valid
- flash_data  in  8  byte read from flash
- led  out  1  debug LED
- busy  out  1  high whenever the command FSM is not in IDLE

Behaviour:
- Reset values:
  - send_data=0x00, flash_addr=0, flash_do_read=0, led=1, busy=1, since the FSM resets to SETUP.
  - FIFO empty; all counters 0.
- Reply timing: send_data updates on the clk edge after recv_ready. The byte loaded in response to received byte k is the one the host sees during byte k+1.
- Command FSM states: SETUP, IDLE, ADDR, LEN, STREAM.
- SETUP:
  - Any received byte -> send_data=0xFD.
  - Go to IDLE on the first cycle flash_setup_done=1.
- IDLE, by opcode:
  - 0x00 -> reply 0x00.
  - 0x02 -> toggle led, reply 0xAB.
  - 0xCC -> reply 0xCC.
  - 0x04 -> reply {4'h0, fifo_count[3:0]}.
  - 0x03 -> reply 0x03, addr_cnt=3, go to ADDR.
  - Any other opcode -> reply 0xEE, stay in IDLE.
- ADDR:
  - Shift the address register left 8 and insert recv_data (MSB first).
  - Reply addr_cnt-1.
  - After the 3rd byte, go to LEN.
- LEN:
  - len = recv_data; 0 means 256. Load fetch_remaining and send_remaining, both 9-bit.
  - Load fetch_addr = the assembled address.
  - Reply 0x00, clear phase bit, go to STREAM.
- STREAM: each received byte is a poll; its value is ignored. Phase bit alternates status/data.
  - Phase 0, FIFO empty -> reply 0xFE; phase unchanged.
  - Phase 0, FIFO non-empty -> reply 0xFF; phase=1.
  - Phase 1 -> pop FIFO, reply the popped byte, decrement send_remaining, phase=0. If send_remaining reaches 0, go to IDLE.
  - Phase 1 is entered only when the FIFO is non-empty, so it never underflows.
- Fetch engine (independent sub-FSM, states F_IDLE and F_WAIT):
  - In F_IDLE, when the command FSM is in STREAM, fetch_remaining>0, and fifo_count+1 ≤ DEPTH: drive flash_addr=fetch_addr, set flash_do_read=1, go to F_WAIT.
  - In F_WAIT, on flash_data_ready: push flash_data, flash_do_read=0, fetch_addr+=1, fetch_remaining-=1, go to F_IDLE.
  - At most one request is outstanding. Minimum gap between requests is 1 cycle (do_read low for at least 1 cycle).
- Address wrap: fetch_addr increments modulo 2^ADDR_W, so 0xFFFFFF -> 0x000000.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and data order is preserved. A byte pushed in cycle t is poppable at t+1 at the earliest.
- flash_data_ready while flash_do_read=0: ignored, no push.
- recv_ready with flash_setup_done=0 in any state: the SETUP rule applies only in SETUP. Setup dropping after SETUP is ignored.
- Reset mid-burst: all state clears asynchronously and flash_do_read drops immediately. The flash controller shares rst.
- No abort: a burst completes only after all len bytes are delivered to the host.

Decomposition:
- Package spi_flash_reader_pkg holds:
  - opcode constants: OP_NOP=0x00, OP_LED=0x02, OP_STAT=0x04, OP_READ=0x03, OP_ECHO=0xCC.
  - reply codes: R_SETUP=0xFD, R_WAIT=0xFE, R_DATA=0xFF, R_BADOP=0xEE.
  - state localparams for both FSMs.
- Sub-module byte_fifo, parameterised by DEPTH:
  - Synchronous push/pop with count, full and empty outputs.
  - Pop on empty and push on full are ignored.

Test Plan:
- Hold flash_setup_done=0, send 0x00 -> reply 0xFD. Raise setup_done, send 0x00, 0x00 -> replies 0x00, 0x00; busy=0.
- Send 0x02, 0x02, 0x00 -> led 1->0->1; replies 0xAB, 0xAB, 0x00.
- Send 0x03,0x12,0x34,0x56,0x02, then polls; flash model returns addr[7:0]. Check:
  - Replies 0x03, 0x02, 0x01, 0x00, 0x00.
  - flash_addr sequence 0x123456, 0x123457.
  - Polls yield 0xFF,0x56,0xFF,0x57, with 0xFE inserted while the FIFO is empty.
  - Final state IDLE.
- Burst len=0x00 at address 0xFFFFFE with a slow host -> exactly 256 flash requests. Check:
  - Addresses wrap 0xFFFFFF -> 0x000000.
  - fifo_count never exceeds 4.
  - flash_do_read stays low while the FIFO is full.
- Fast host polling against a 20-cycle flash latency -> repeated 0xFE replies, no spurious 0xFF, data in order.
- Assert rst mid-burst while flash_do_read=1 -> do_read=0, send_data=0x00, led=1, FIFO empty in the same cycle. After setup_done, 0xCC -> reply 0xCC.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared opcodes, reply codes and FSM state types for the SPI flash command engine.
package spi_flash_reader_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LED  = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_STAT = 8'h04;
    localparam logic [7:0] OP_ECHO = 8'hCC;

    localparam logic [7:0] R_SETUP = 8'hFD;
    localparam logic [7:0] R_WAIT  = 8'hFE;
    localparam logic [7:0] R_DATA  = 8'hFF;
    localparam logic [7:0] R_BADOP = 8'hEE;

    typedef enum logic [2:0] {S_SETUP, S_IDLE, S_ADDR, S_LEN, S_STREAM} cmd_state_t;
    typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

    // A length byte of zero encodes a full 256-byte burst.
    function automatic logic [8:0] burst_len(input logic [7:0] b);
        return (b == 8'd0) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/spi_flash_reader_fifo.sv
// Small prefetch FIFO; pushes when full and pops when empty are dropped.
module byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  pop_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// Host command parser plus an independent flash prefetch engine feeding a byte FIFO.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        recv_data,
    input  logic              recv_ready,
    output logic [7:0]        send_data,
    input  logic              flash_setup_done,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_do_read,
    input  logic              flash_data_ready,
    input  logic [7:0]        flash_data,
    output logic              led,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    cmd_state_t        state;
    fetch_state_t      fstate;
    logic [ADDR_W-1:0] addr_reg, fetch_addr;
    logic [1:0]        addr_cnt;
    logic [8:0]        fetch_remaining, send_remaining;
    logic              phase;

    logic [CW-1:0] fifo_count;
    logic [3:0]    cnt4;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop, load_burst;

    assign busy       = (state != S_IDLE);
    assign cnt4       = 4'(fifo_count);
    assign load_burst = recv_ready && (state == S_LEN);
    assign fifo_pop   = recv_ready && (state == S_STREAM) && phase;
    assign fifo_push  = (fstate == F_WAIT) && flash_data_ready;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (flash_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_SETUP;
            send_data      <= 8'h00;
            led            <= 1'b1;
            addr_reg       <= '0;
            addr_cnt       <= '0;
            send_remaining <= '0;
            phase          <= 1'b0;
        end else begin
            case (state)
                S_SETUP: begin
                    if (recv_ready) send_data <= R_SETUP;
                    if (flash_setup_done) state <= S_IDLE;
                end
                S_IDLE: if (recv_ready) begin
                    case (recv_data)
                        OP_NOP:  send_data <= 8'h00;
                        OP_LED:  begin led <= !led; send_data <= 8'hAB; end
                        OP_ECHO: send_data <= OP_ECHO;
                        OP_STAT: send_data <= {4'h0, cnt4};
                        OP_READ: begin
                            send_data <= OP_READ;
                            addr_cnt  <= 2'd3;
                            state     <= S_ADDR;
                        end
                        default: send_data <= R_BADOP;
                    endcase
                end
                S_ADDR: if (recv_ready) begin
                    addr_reg  <= {addr_reg[ADDR_W-9:0], recv_data};
                    send_data <= {6'd0, addr_cnt - 2'd1};
                    addr_cnt  <= addr_cnt - 2'd1;
                    if (addr_cnt == 2'd1) state <= S_LEN;
                end
                S_LEN: if (recv_ready) begin
                    send_remaining <= burst_len(recv_data);
                    send_data      <= 8'h00;
                    phase          <= 1'b0;
                    state          <= S_STREAM;
                end
                S_STREAM: if (recv_ready) begin
                    // Status poll first; data is only offered once a byte is known to be queued.
                    if (phase) begin
                        send_data      <= fifo_dout;
                        send_remaining <= send_remaining - 9'd1;
                        phase          <= 1'b0;
                        if (send_remaining == 9'd1) state <= S_IDLE;
                    end else if (fifo_empty) begin
                        send_data <= R_WAIT;
                    end else begin
                        send_data <= R_DATA;
                        phase     <= 1'b1;
                    end
                end
                default: state <= S_SETUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate          <= F_IDLE;
            flash_do_read   <= 1'b0;
            flash_addr      <= '0;
            fetch_addr      <= '0;
            fetch_remaining <= '0;
        end else begin
            if (load_burst) begin
                fetch_addr      <= addr_reg;
                fetch_remaining <= burst_len(recv_data);
            end
            case (fstate)
                F_IDLE: if (state == S_STREAM && fetch_remaining != 9'd0 && !fifo_full) begin
                    flash_addr    <= fetch_addr;
                    flash_do_read <= 1'b1;
                    fstate        <= F_WAIT;
                end
                F_WAIT: if (flash_data_ready) begin
                    flash_do_read   <= 1'b0;
                    fetch_addr      <= fetch_addr + ADDR_W'(1);
                    fetch_remaining <= fetch_remaining - 9'd1;
                    fstate          <= F_IDLE;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomised host/flash stimulus against a byte-level protocol model with a reply scoreboard.
module tb_spi_flash_reader;
    localparam int DEPTH = 4;
    localparam int ADDR_W = 24;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] recv_data = 8'h00;
    logic recv_ready = 1'b0;
    logic [7:0] send_data;
    logic flash_setup_done = 1'b0;
    logic [ADDR_W-1:0] flash_addr;
    logic flash_do_read;
    logic flash_data_ready = 1'b0;
    logic [7:0] flash_data = 8'h00;
    logic led, busy;

    always #5 clk = ~clk;

    spi_flash_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .recv_data(recv_data), .recv_ready(recv_ready),
        .send_data(send_data), .flash_setup_done(flash_setup_done),
        .flash_addr(flash_addr), .flash_do_read(flash_do_read),
        .flash_data_ready(flash_data_ready), .flash_data(flash_data),
        .led(led), .busy(busy)
    );

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: host-visible state as counts of header bytes and data bytes owed.
    bit        m_setup = 1'b1;
    bit        m_led = 1'b1;
    bit        m_phase = 1'b0;
    int        m_hdr = 0;
    int        m_send = 0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_fifo[$];
    logic [7:0]  exp_q[$];
    logic [23:0] addr_q[$];
    int        n_recv = 0;
    bit        legit = 1'b0;
    int        lat = 1;
    int        n_req = 0;
    int        spur_req = 0;

    function automatic logic [7:0] reply(input logic [7:0] b);
        if (m_setup) return 8'hFD;
        if (m_hdr > 0) begin
            m_hdr--;
            if (m_hdr > 0) begin
                m_addr = {m_addr[15:0], b};
                return 8'(m_hdr - 1);
            end
            m_send = (b == 8'd0) ? 256 : int'(b);
            for (int i = 0; i < m_send; i++) addr_q.push_back(m_addr + 24'(i));
            m_phase = 1'b0;
            return 8'h00;
        end
        if (m_send > 0) begin
            if (m_phase) begin
                m_phase = 1'b0;
                m_send--;
                return m_fifo.pop_front();
            end
            if (m_fifo.size() == 0) return 8'hFE;
            m_phase = 1'b1;
            return 8'hFF;
        end
        case (b)
            8'h00: return 8'h00;
            8'h02: begin m_led = !m_led; return 8'hAB; end
            8'hCC: return 8'hCC;
            8'h04: return 8'(m_fifo.size());
            8'h03: begin m_hdr = 4; m_addr = '0; return 8'h03; end
            default: return 8'hEE;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_setup = 1'b1; m_led = 1'b1; m_phase = 1'b0; m_hdr = 0; m_send = 0;
            m_fifo.delete(); exp_q.delete(); addr_q.delete();
        end else begin
            if (recv_ready) begin
                exp_q.push_back(reply(recv_data));
                n_recv++;
            end
            if (legit) m_fifo.push_back(flash_data);
            if (m_setup && flash_setup_done) m_setup = 1'b0;
        end
    end

    // Monitor: compares every reply and the continuous outputs against the model.
    int n_done = 0;
    always @(negedge clk) begin
        if (rst) begin
            n_done = n_recv;
        end else begin
            while (n_done < n_recv) begin
                n_done++;
                if (exp_q.size() == 0) check("reply_missing_exp", 32'(send_data), 32'hFFFF_FFFF);
                else check("reply", 32'(send_data), 32'(exp_q.pop_front()));
            end
            check("led", 32'(led), 32'(m_led));
            check("busy", 32'(busy), 32'(m_setup || m_hdr > 0 || m_send > 0));
            check("fifo_fill_le_depth", 32'(m_fifo.size() <= DEPTH), 32'd1);
            if (m_fifo.size() == DEPTH) check("no_read_when_full", 32'(flash_do_read), 32'd0);
        end
    end

    // Flash responder: latency `lat`, returns addr[7:0], checks address order and request gap.
    bit   f_busy = 1'b0, f_gap = 1'b0;
    int   f_cnt = 0, spur_done = 0;
    logic [23:0] f_addr = '0;
    always @(negedge clk) begin
        flash_data_ready = 1'b0;
        legit = 1'b0;
        if (rst) begin
            f_busy = 1'b0; f_gap = 1'b0;
        end else if (f_gap) begin
            f_gap = 1'b0;
            check("req_gap", 32'(flash_do_read), 32'd0);
        end else if (f_busy) begin
            if (f_cnt == 0) begin
                check("addr_stable", 32'(flash_addr), 32'(f_addr));
                flash_data_ready = 1'b1;
                flash_data = f_addr[7:0];
                legit = 1'b1;
                f_busy = 1'b0;
                f_gap = 1'b1;
            end else f_cnt--;
        end else if (flash_do_read) begin
            n_req++;
            f_addr = flash_addr;
            if (addr_q.size() == 0) check("extra_request", 32'(flash_addr), 32'hFFFF_FFFF);
            else check("flash_addr", 32'(flash_addr), 32'(addr_q.pop_front()));
            f_busy = 1'b1;
            f_cnt = lat;
        end else if (spur_done < spur_req) begin
            spur_done++;
            flash_data_ready = 1'b1;
            flash_data = 8'h5A;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        recv_data = b;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic burst(input logic [23:0] a, input logic [7:0] len, input int gap);
        int r0, polls;
        r0 = n_req;
        polls = 0;
        send(8'h03, gap); send(a[23:16], gap); send(a[15:8], gap); send(a[7:0], gap);
        send(len, gap);
        while (m_send > 0 && polls < 5000) begin
            send(8'($urandom), gap);
            polls++;
        end
        if (polls >= 5000) check("poll_budget", 32'(polls), 32'd4999);
        repeat (3) @(negedge clk);
        check("req_count", 32'(n_req - r0), (len == 8'd0) ? 32'd256 : 32'(len));
        check("idle_after_burst", 32'(busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_send_data", 32'(send_data), 32'h00);
        check("rst_do_read", 32'(flash_do_read), 32'd0);
        check("rst_flash_addr", 32'(flash_addr), 32'd0);
        check("rst_led", 32'(led), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        send(8'h00, 2);
        flash_setup_done = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h00, 1); send(8'h00, 1);
        send(8'h02, 1); send(8'h02, 1); send(8'h00, 1);
        send(8'hCC, 1); send(8'h04, 1); send(8'h77, 0); send(8'h01, 2);
        flash_setup_done = 1'b0;            // dropping setup after SETUP is ignored
        spur_req++;
        repeat (3) @(negedge clk);
        send(8'h04, 1); send(8'hCC, 1);
        flash_setup_done = 1'b1;

        lat = 3;
        burst(24'h123456, 8'h02, 2);

        for (int k = 0; k < 6; k++) begin
            lat = int'($urandom_range(0, 5));
            burst(24'($urandom), 8'($urandom_range(1, 20)), int'($urandom_range(0, 4)));
        end

        lat = 1;
        burst(24'hFFFFFE, 8'h00, 10);

        lat = 20;
        burst(24'($urandom), 8'd4, 0);

        // Reset while a flash request is outstanding.
        send(8'h02, 1);
        lat = 30;
        send(8'h03, 1); send(8'hAB, 1); send(8'hCD, 1); send(8'hEF, 1); send(8'd10, 1);
        for (int i = 0; i < 20 && !flash_do_read; i++) @(negedge clk);
        check("read_before_rst", 32'(flash_do_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_do_read", 32'(flash_do_read), 32'd0);
        check("midrst_send_data", 32'(send_data), 32'h00);
        check("midrst_led", 32'(led), 32'd1);
        check("midrst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        repeat (2) @(negedge clk);
        send(8'h04, 1); send(8'hCC, 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
